// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory-bus arbiter.
// The request/response structs are sized by ARB_XLEN, which the arbiter's XLEN must match.
package mem_arbiter_pkg;

  localparam int ARB_XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_XLEN-1:0]   addr;
    logic [ARB_XLEN-1:0]   wdata;
    logic [ARB_XLEN/8-1:0] be;
  } mem_req_t;

  typedef struct packed {
    logic                valid;
    logic [ARB_XLEN-1:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-ported memory bus arbiter between fetch (I) and data (D) requesters.
// One transaction in flight; D has priority unless fetch has lost MAX_D_WINS grants in a row.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = ARB_XLEN,
  parameter int MAX_D_WINS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic [XLEN-1:0]   i_req_addr,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [XLEN-1:0]   i_resp_rdata,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [XLEN/8-1:0] d_req_be,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [XLEN-1:0]   d_resp_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_we,
  output logic [XLEN-1:0]   m_req_addr,
  output logic [XLEN-1:0]   m_req_wdata,
  output logic [XLEN/8-1:0] m_req_be,
  input  logic              m_resp_valid,
  input  logic [XLEN-1:0]   m_resp_rdata,
  output logic              i_stall,
  output logic              d_stall,
  output logic              spurious_resp
);

  localparam int              CNT_W   = $clog2(MAX_D_WINS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_WINS);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  mem_req_t         req_q, req_d;
  logic [CNT_W-1:0] d_win_cnt_q, d_win_cnt_d;
  logic             spurious_q, spurious_d;
  logic             grant_i, grant_d;
  logic             resp_hit;
  mem_resp_t        i_resp, d_resp;

  // Fetch overrides the default data priority only once it has been starved.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (d_req_valid && !(i_req_valid && (d_win_cnt_q == CNT_MAX))) begin
        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_d       = req_q;
    d_win_cnt_d = d_win_cnt_q;
    spurious_d  = spurious_q | (m_resp_valid & (state_q != ARB_WAIT));
    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          owner_d     = OWN_D;
          req_d       = '{we: d_req_we, addr: d_req_addr, wdata: d_req_wdata, be: d_req_be};
          d_win_cnt_d = i_req_valid ? d_win_cnt_q + 1'b1 : '0;
          state_d     = ARB_REQ;
        end else if (grant_i) begin
          owner_d     = OWN_I;
          req_d       = '{we: 1'b0, addr: i_req_addr, wdata: '0, be: '1};
          d_win_cnt_d = '0;
          state_d     = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (m_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (m_resp_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_I;
      req_q       <= '0;
      d_win_cnt_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      d_win_cnt_q <= d_win_cnt_d;
      spurious_q  <= spurious_d;
    end
  end

  // Every output is gated by reset so nothing leaks while it is held low.
  always_comb begin
    resp_hit     = reset & (state_q == ARB_WAIT) & m_resp_valid;
    i_resp.valid = resp_hit & (owner_q == OWN_I);
    i_resp.rdata = i_resp.valid ? m_resp_rdata : '0;
    d_resp.valid = resp_hit & (owner_q == OWN_D);
    d_resp.rdata = d_resp.valid ? m_resp_rdata : '0;
  end

  assign i_req_ready   = reset & grant_i;
  assign d_req_ready   = reset & grant_d;
  assign i_resp_valid  = i_resp.valid;
  assign i_resp_rdata  = i_resp.rdata;
  assign d_resp_valid  = d_resp.valid;
  assign d_resp_rdata  = d_resp.rdata;

  assign m_req_valid   = reset & (state_q == ARB_REQ);
  assign m_req_we      = m_req_valid & req_q.we;
  assign m_req_addr    = m_req_valid ? req_q.addr  : '0;
  assign m_req_wdata   = m_req_valid ? req_q.wdata : '0;
  assign m_req_be      = m_req_valid ? req_q.be    : '0;

  assign i_stall       = reset & i_req_valid & ~i_resp.valid;
  assign d_stall       = reset & d_req_valid & ~d_resp.valid;
  assign spurious_resp = reset & spurious_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model with a behavioural memory.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int MAXW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req_valid;
  logic [XLEN-1:0]   i_req_addr;
  logic              i_req_ready;
  logic              i_resp_valid;
  logic [XLEN-1:0]   i_resp_rdata;
  logic              d_req_valid;
  logic              d_req_we;
  logic [XLEN-1:0]   d_req_addr;
  logic [XLEN-1:0]   d_req_wdata;
  logic [XLEN/8-1:0] d_req_be;
  logic              d_req_ready;
  logic              d_resp_valid;
  logic [XLEN-1:0]   d_resp_rdata;
  logic              m_req_valid;
  logic              m_req_ready;
  logic              m_req_we;
  logic [XLEN-1:0]   m_req_addr;
  logic [XLEN-1:0]   m_req_wdata;
  logic [XLEN/8-1:0] m_req_be;
  logic              m_resp_valid;
  logic [XLEN-1:0]   m_resp_rdata;
  logic              i_stall;
  logic              d_stall;
  logic              spurious_resp;
  logic [140:0]      all_out;

  int checks = 0;
  int passed = 0;

  mem_arbiter #(.XLEN(XLEN), .MAX_D_WINS(MAXW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_be(m_req_be),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .i_stall(i_stall), .d_stall(d_stall), .spurious_resp(spurious_resp)
  );

  always #5 clk = ~clk;

  assign all_out = {i_req_ready, i_resp_valid, i_resp_rdata, d_req_ready, d_resp_valid,
                    d_resp_rdata, m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_be,
                    i_stall, d_stall, spurious_resp};

  task automatic clr_inputs();
    i_req_valid  = 1'b0; i_req_addr  = '0;
    d_req_valid  = 1'b0; d_req_we    = 1'b0; d_req_addr = '0;
    d_req_wdata  = '0;   d_req_be    = '0;
    m_req_ready  = 1'b0; m_resp_valid = 1'b0; m_resp_rdata = '0;
  endtask

  task automatic apply_reset();
    clr_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clr_inputs();
    reset = 1'b0;
    i_req_valid = 1'b1; i_req_addr = '1; d_req_valid = 1'b1; d_req_we = 1'b1;
    d_req_addr = '1; d_req_wdata = '1; d_req_be = '1;
    m_req_ready = 1'b1; m_resp_valid = 1'b1; m_resp_rdata = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (all_out !== '0) $display("FAIL reset_outputs_zero cycle %0d got %h want 0", c, all_out);
      else passed++;
    end
    @(negedge clk);
    clr_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL reset_release_idle got %h want 0", all_out);
    else passed++;
  endtask

  task automatic test_single_fetch();
    apply_reset();
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h100; m_req_ready = 1'b1;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready, i_stall, m_req_valid} !== 4'b1010)
      $display("FAIL fetch_grant got %b want 1010", {i_req_ready, d_req_ready, i_stall, m_req_valid});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({m_req_valid, m_req_we, m_req_be, m_req_addr, i_resp_valid} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0})
      $display("FAIL fetch_mreq got v=%b we=%b be=%h a=%h want v=1 we=0 be=f a=100",
               m_req_valid, m_req_we, m_req_be, m_req_addr);
    else passed++;
    @(negedge clk);
    m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_rdata = 32'h0000_0013;
    #1;
    checks++;
    if ({i_resp_valid, i_resp_rdata, d_resp_valid, d_resp_rdata, i_stall, d_stall}
        !== {1'b1, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0})
      $display("FAIL fetch_resp got iv=%b ir=%h dv=%b dr=%h want iv=1 ir=13 dv=0 dr=0",
               i_resp_valid, i_resp_rdata, d_resp_valid, d_resp_rdata);
    else passed++;
    @(negedge clk);
    clr_inputs();
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL fetch_after_idle got %h want 0", all_out);
    else passed++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h104;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h200;
    d_req_wdata = 32'hDEAD_BEEF; d_req_be = 4'h3; m_req_ready = 1'b1;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready, i_stall, d_stall} !== 4'b0111)
      $display("FAIL simul_d_first got %b want 0111", {i_req_ready, d_req_ready, i_stall, d_stall});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({m_req_valid, m_req_we, m_req_be, m_req_addr, m_req_wdata, i_stall}
        !== {1'b1, 1'b1, 4'h3, 32'h200, 32'hDEAD_BEEF, 1'b1})
      $display("FAIL simul_store_req got we=%b be=%h a=%h w=%h want we=1 be=3 a=200 w=deadbeef",
               m_req_we, m_req_be, m_req_addr, m_req_wdata);
    else passed++;
    @(negedge clk);
    m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_rdata = 32'h77;
    #1;
    checks++;
    if ({d_resp_valid, i_resp_valid, d_stall, i_stall} !== 4'b1001)
      $display("FAIL simul_store_ack got %b want 1001", {d_resp_valid, i_resp_valid, d_stall, i_stall});
    else passed++;
    @(negedge clk);
    d_req_valid = 1'b0; m_resp_valid = 1'b0; m_req_ready = 1'b1;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready, i_stall} !== 3'b101)
      $display("FAIL simul_i_second got %b want 101", {i_req_ready, d_req_ready, i_stall});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({m_req_valid, m_req_we, m_req_be, m_req_addr} !== {1'b1, 1'b0, 4'hF, 32'h104})
      $display("FAIL simul_fetch_req got we=%b be=%h a=%h want we=0 be=f a=104", m_req_we, m_req_be, m_req_addr);
    else passed++;
    @(negedge clk);
    m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_rdata = 32'h1234;
    #1;
    checks++;
    if ({i_resp_valid, d_resp_valid, i_stall, i_resp_rdata} !== {3'b100, 32'h1234})
      $display("FAIL simul_fetch_resp got iv=%b dv=%b st=%b r=%h want 1 0 0 1234",
               i_resp_valid, d_resp_valid, i_stall, i_resp_rdata);
    else passed++;
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_starvation();
    int  cnt = 0;
    int  ng  = 0;
    bit  hs_prev = 1'b0;
    bit  exp_i;
    apply_reset();
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 32'h500;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h600;
      m_req_ready = 1'b1; m_resp_valid = hs_prev; m_resp_rdata = 32'(c);
      #1;
      hs_prev = m_req_valid & m_req_ready;
      if (i_req_ready | d_req_ready) begin
        exp_i = (cnt == MAXW);
        checks++;
        if ({i_req_ready, d_req_ready} !== {exp_i, ~exp_i})
          $display("FAIL starve_grant_%0d got i=%b d=%b want i=%b d=%b",
                   ng, i_req_ready, d_req_ready, exp_i, ~exp_i);
        else passed++;
        cnt = exp_i ? 0 : cnt + 1;
        ng++;
      end
    end
    checks++;
    if (ng != 10) $display("FAIL starve_timeout got %0d grants want 10", ng);
    else passed++;
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h300;
    d_req_wdata = 32'hA5A5_5A5A; d_req_be = 4'hC;
    #1;
    checks++;
    if (d_req_ready !== 1'b1) $display("FAIL bp_grant got %b want 1", d_req_ready);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({m_req_valid, m_req_addr, m_req_wdata, m_req_be, i_resp_valid, d_resp_valid}
          !== {1'b1, 32'h300, 32'hA5A5_5A5A, 4'hC, 2'b00})
        $display("FAIL bp_hold_%0d got v=%b a=%h w=%h be=%h rv=%b%b", c, m_req_valid, m_req_addr,
                 m_req_wdata, m_req_be, i_resp_valid, d_resp_valid);
      else passed++;
    end
    @(negedge clk);
    m_req_ready = 1'b1;
    #1;
    checks++;
    if (m_req_valid !== 1'b1) $display("FAIL bp_accept got %b want 1", m_req_valid);
    else passed++;
    @(negedge clk);
    m_req_ready = 1'b0; m_resp_valid = 1'b1;
    #1;
    checks++;
    if ({d_resp_valid, i_resp_valid, m_req_valid} !== 3'b100)
      $display("FAIL bp_complete got %b want 100", {d_resp_valid, i_resp_valid, m_req_valid});
    else passed++;
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 32'h400; m_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL rstmid_wait_zero got %h want 0", all_out);
    else passed++;
    @(negedge clk);
    m_resp_valid = 1'b1; m_resp_rdata = 32'hFEED_F00D;
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL rstmid_resp_dropped got %h want 0", all_out);
    else passed++;
    @(negedge clk);
    clr_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL rstmid_release got %h want 0", all_out);
    else passed++;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    #1;
    checks++;
    if ({i_req_ready, spurious_resp} !== 2'b10)
      $display("FAIL rstmid_idle_grant got rdy=%b sp=%b want 1 0", i_req_ready, spurious_resp);
    else passed++;
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_spurious();
    apply_reset();
    @(negedge clk);
    m_resp_valid = 1'b1; m_resp_rdata = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({i_resp_valid, d_resp_valid, spurious_resp} !== 3'b000)
      $display("FAIL spur_no_route got %b want 000", {i_resp_valid, d_resp_valid, spurious_resp});
    else passed++;
    @(negedge clk);
    m_resp_valid = 1'b0; m_req_ready = 1'b1;
    #1;
    checks++;
    if ({spurious_resp, m_req_valid} !== 2'b10)
      $display("FAIL spur_set got sp=%b mv=%b want 1 0", spurious_resp, m_req_valid);
    else passed++;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    m_req_ready = 1'b0; m_resp_valid = 1'b1; m_resp_rdata = 32'h99;
    #1;
    checks++;
    if ({i_resp_valid, spurious_resp} !== 2'b11)
      $display("FAIL spur_sticky got iv=%b sp=%b want 1 1", i_resp_valid, spurious_resp);
    else passed++;
    apply_reset();
    #1;
    checks++;
    if (spurious_resp !== 1'b0) $display("FAIL spur_cleared got %b want 0", spurious_resp);
    else passed++;
  endtask

  logic [31:0] refmem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : ~a;
  endfunction

  task automatic test_random();
    bit ip = 0, dp = 0, dwe = 0;
    logic [31:0] ia = '0, da = '0, dw = '0;
    logic [3:0]  dbe = '0;
    bit busy = 0, own_d = 0, reqph = 0, mpend = 0;
    int cnt = 0, mdelay = 0, done = 0;
    logic        mwe = 1'b0;
    logic [31:0] maddr = '0, mwdata = '0;
    logic [3:0]  mbe = '0;
    bit exp_gi, exp_gd, exp_ir, exp_dr;
    logic [31:0] merged;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!ip && ($urandom_range(0, 2) == 0)) begin
        ip = 1; ia = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dp && ($urandom_range(0, 2) == 0)) begin
        dp = 1; dwe = 1'($urandom_range(0, 1)); da = 32'($urandom_range(0, 15)) << 2;
        dw = $urandom; dbe = 4'($urandom_range(1, 15));
      end
      i_req_valid = ip; i_req_addr = ia;
      d_req_valid = dp; d_req_we = dwe; d_req_addr = da; d_req_wdata = dw; d_req_be = dbe;
      m_req_ready  = 1'($urandom_range(0, 1));
      m_resp_valid = mpend && (mdelay == 0);
      m_resp_rdata = (m_resp_valid && !mwe) ? rd(maddr) : $urandom;
      #1;
      exp_gi = 0; exp_gd = 0;
      if (!busy) begin
        if (dp && !(ip && cnt == MAXW)) exp_gd = 1;
        else if (ip) exp_gi = 1;
      end
      exp_ir = m_resp_valid && !own_d;
      exp_dr = m_resp_valid && own_d;
      checks++;
      if ({i_req_ready, d_req_ready, m_req_valid} !== {exp_gi, exp_gd, reqph})
        $display("FAIL rand_grant c%0d got i=%b d=%b mv=%b want %b %b %b", c,
                 i_req_ready, d_req_ready, m_req_valid, exp_gi, exp_gd, reqph);
      else passed++;
      checks++;
      if ({i_resp_valid, d_resp_valid, i_stall, d_stall} !== {exp_ir, exp_dr, ip & ~exp_ir, dp & ~exp_dr})
        $display("FAIL rand_resp c%0d got %b want %b", c, {i_resp_valid, d_resp_valid, i_stall, d_stall},
                 {exp_ir, exp_dr, ip & ~exp_ir, dp & ~exp_dr});
      else passed++;
      if (exp_ir || (exp_dr && !dwe)) begin
        checks++;
        if ((exp_ir ? i_resp_rdata : d_resp_rdata) !== rd(exp_ir ? ia : da))
          $display("FAIL rand_rdata c%0d got %h want %h", c,
                   exp_ir ? i_resp_rdata : d_resp_rdata, rd(exp_ir ? ia : da));
        else passed++;
      end
      if (reqph && m_req_ready) begin
        checks++;
        if (own_d ? ({m_req_we, m_req_addr, m_req_be} !== {dwe, da, dbe}) ||
                    (dwe && m_req_wdata !== dw)
                  : ({m_req_we, m_req_addr, m_req_be} !== {1'b0, ia, 4'hF}))
          $display("FAIL rand_mreq c%0d got we=%b a=%h w=%h be=%h owner_d=%0d", c,
                   m_req_we, m_req_addr, m_req_wdata, m_req_be, own_d);
        else passed++;
        mpend = 1; mdelay = $urandom_range(0, 2);
        mwe = m_req_we; maddr = m_req_addr; mwdata = m_req_wdata; mbe = m_req_be;
        reqph = 0;
      end else if (m_resp_valid) begin
        if (mwe) begin
          merged = rd(maddr);
          for (int b = 0; b < 4; b++)
            if (mbe[b]) merged[b*8 +: 8] = mwdata[b*8 +: 8];
          refmem[maddr] = merged;
        end
        if (own_d) dp = 0; else ip = 0;
        busy = 0; mpend = 0; done++;
      end else if (mpend && mdelay > 0) begin
        mdelay--;
      end
      if (exp_gd) begin
        busy = 1; own_d = 1; reqph = 1; cnt = ip ? cnt + 1 : 0;
      end else if (exp_gi) begin
        busy = 1; own_d = 0; reqph = 1; cnt = 0;
      end
    end
    checks++;
    if (done < 100) $display("FAIL rand_progress got %0d transactions want >=100", done);
    else passed++;
    @(negedge clk);
    clr_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clr_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
